// File: rtl/pair_gen_pkg.sv
// Shared types and constants for the pair generator.
// Position words are packed {z,y,x}, each DATA_WIDTH bits wide.
package pair_gen_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int POS_STRUCT_WIDTH = 3 * DATA_WIDTH;
  localparam int PAIR_ID_WIDTH    = 7;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] z;
    logic [DATA_WIDTH-1:0] y;
    logic [DATA_WIDTH-1:0] x;
  } pos_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pair_gen_state_t;

endpackage

// File: rtl/pair_gen_if.sv
// Bundle of the pair generator's control, position-RAM and pair-output signals.
// master: the generator itself; slave: the surrounding logic (control, RAMs, converter).
interface pair_gen_if import pair_gen_pkg::*; #(
  parameter int ID_WIDTH = PAIR_ID_WIDTH
) ();

  // sweep control
  logic                        i_start;
  logic [ID_WIDTH-1:0]         i_home_cnt;
  logic [ID_WIDTH-1:0]         i_nb_cnt;
  logic                        i_same_cell;
  logic                        i_stall;
  // position RAM read ports
  logic [ID_WIDTH-1:0]         o_home_addr;
  logic [ID_WIDTH-1:0]         o_nb_addr;
  logic [POS_STRUCT_WIDTH-1:0] i_home_rdata;
  logic [POS_STRUCT_WIDTH-1:0] i_nb_rdata;
  // pair output towards the fixed->float converter
  logic [POS_STRUCT_WIDTH-1:0] o_home_pos;
  logic [POS_STRUCT_WIDTH-1:0] o_nb_pos;
  logic [ID_WIDTH-1:0]         o_home_id;
  logic [ID_WIDTH-1:0]         o_nb_id;
  logic                        o_pair_valid;
  // status
  logic                        o_busy;
  logic                        o_done;

  modport master (
    input  i_start, i_home_cnt, i_nb_cnt, i_same_cell, i_stall,
    input  i_home_rdata, i_nb_rdata,
    output o_home_addr, o_nb_addr,
    output o_home_pos, o_nb_pos, o_home_id, o_nb_id, o_pair_valid,
    output o_busy, o_done
  );

  modport slave (
    output i_start, i_home_cnt, i_nb_cnt, i_same_cell, i_stall,
    output i_home_rdata, i_nb_rdata,
    input  o_home_addr, o_nb_addr,
    input  o_home_pos, o_nb_pos, o_home_id, o_nb_id, o_pair_valid,
    input  o_busy, o_done
  );

endinterface

// File: rtl/pair_gen.sv
// Pair generator: walks every (home, neighbour) particle pair of one cell pair,
// home index outer, neighbour index inner, one address pair per unstalled cycle.
// Pipeline: address reg (k) -> RAM data (k+1) -> registered pair output (k+2).
// Optional macro PAIR_SKIP_SELF_EN: with i_same_cell=1 only the upper triangle
// (nb_id > home_id) is swept.
module pair_gen import pair_gen_pkg::*; #(
  parameter int ID_WIDTH    = PAIR_ID_WIDTH,
  parameter int RAM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  pair_gen_if.master bus
);

  typedef logic [ID_WIDTH-1:0] id_t;

  // The output stage assumes data arrives exactly one cycle after the address.
  generate
    if (RAM_LATENCY != 1) begin : g_bad_latency
      $error("pair_gen: RAM_LATENCY=%0d is not supported (only 1)", RAM_LATENCY);
    end
  endgenerate

  pair_gen_state_t r_state;
  pair_gen_state_t w_state_next;

  // captured sweep parameters
  id_t  r_home_cnt;
  id_t  r_nb_cnt;
  logic r_same;
  // next pair to issue while in RUN
  id_t  r_h;
  id_t  r_n;
  // stage A: issued address (also the ids of the pair in flight)
  id_t  r_home_addr;
  id_t  r_nb_addr;
  logic r_a_valid;
  // stage B: ids aligned with RAM read data
  id_t  r_b_home_id;
  id_t  r_b_nb_id;
  logic r_b_valid;
  // stage C: registered pair output
  logic [POS_STRUCT_WIDTH-1:0] r_home_pos;
  logic [POS_STRUCT_WIDTH-1:0] r_nb_pos;
  id_t  r_home_id;
  id_t  r_nb_id;
  logic r_pair_valid;

  logic w_skip_in;
`ifdef PAIR_SKIP_SELF_EN
  assign w_skip_in = bus.i_same_cell;
`else
  logic w_unused_same_cell;
  assign w_skip_in          = 1'b0;
  assign w_unused_same_cell = bus.i_same_cell;
`endif

  // In IDLE the live inputs describe the sweep being started; afterwards the captured copies do.
  logic w_idle;
  id_t  w_hc;
  id_t  w_nc;
  logic w_skip;
  assign w_idle = (r_state == IDLE);
  assign w_hc   = w_idle ? bus.i_home_cnt : r_home_cnt;
  assign w_nc   = w_idle ? bus.i_nb_cnt   : r_nb_cnt;
  assign w_skip = w_idle ? w_skip_in      : r_same;

  // An empty sweep emits nothing; the triangle of a single particle is empty too.
  logic w_empty;
  logic w_start_ok;
  assign w_empty    = (w_hc == '0) || (w_nc == '0) || (w_skip && (w_hc < id_t'(2)));
  assign w_start_ok = w_idle && bus.i_start;

  // Pair considered for issue this cycle and the pair that follows it.
  id_t  w_first_n;
  id_t  w_cur_h;
  id_t  w_cur_n;
  id_t  w_last_h;
  logic w_wrap;
  logic w_is_last;
  id_t  w_nxt_h;
  id_t  w_nxt_n;
  assign w_first_n = w_skip ? id_t'(1) : '0;
  assign w_cur_h   = w_idle ? '0 : r_h;
  assign w_cur_n   = w_idle ? w_first_n : r_n;
  // With the triangle the last row (h = N-1) has no candidates, so the sweep ends on row N-2.
  assign w_last_h  = w_skip ? (w_hc - id_t'(2)) : (w_hc - id_t'(1));
  assign w_wrap    = (w_cur_n == (w_nc - id_t'(1)));
  assign w_is_last = (w_cur_h == w_last_h) && w_wrap;
  assign w_nxt_h   = w_wrap ? (w_cur_h + id_t'(1)) : w_cur_h;
  assign w_nxt_n   = w_wrap ? (w_skip ? (w_cur_h + id_t'(2)) : '0) : (w_cur_n + id_t'(1));

  logic w_issue;
  logic w_busy;
  logic w_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; the first pair is issued on the start edge itself.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          if (w_empty)                  w_state_next = DONE;
          else if (w_issue && w_is_last) w_state_next = DRAIN;
          else                          w_state_next = RUN;
        end
      end
      RUN:   if (w_issue && w_is_last) w_state_next = DRAIN;
      DRAIN: if (!r_a_valid && !r_b_valid) w_state_next = DONE;
      DONE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output/control decode: issue gating, busy and done.
  always_comb begin
    w_issue = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE:  w_issue = bus.i_start && !w_empty && !bus.i_stall;
      RUN: begin
        w_issue = !bus.i_stall;
        w_busy  = 1'b1;
      end
      DRAIN: w_busy = 1'b1;
      DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Capture sweep parameters on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_home_cnt <= '0;
      r_nb_cnt   <= '0;
      r_same     <= 1'b0;
    end else if (w_start_ok) begin
      r_home_cnt <= bus.i_home_cnt;
      r_nb_cnt   <= bus.i_nb_cnt;
      r_same     <= w_skip_in;
    end
  end

  // Pair counters and address registers; a stall freezes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h         <= '0;
      r_n         <= '0;
      r_home_addr <= '0;
      r_nb_addr   <= '0;
      r_a_valid   <= 1'b0;
    end else begin
      r_a_valid <= w_issue;
      if (w_issue) begin
        r_home_addr <= w_cur_h;
        r_nb_addr   <= w_cur_n;
        r_h         <= w_nxt_h;
        r_n         <= w_nxt_n;
      end else if (w_start_ok) begin
        r_h <= '0;
        r_n <= w_first_n;
      end
    end
  end

  // Delay ids by one cycle so they line up with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_valid   <= 1'b0;
      r_b_home_id <= '0;
      r_b_nb_id   <= '0;
    end else begin
      r_b_valid <= r_a_valid;
      if (r_a_valid) begin
        r_b_home_id <= r_home_addr;
        r_b_nb_id   <= r_nb_addr;
      end
    end
  end

  // Registered pair output; positions and ids hold while no pair is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair_valid <= 1'b0;
      r_home_pos   <= '0;
      r_nb_pos     <= '0;
      r_home_id    <= '0;
      r_nb_id      <= '0;
    end else begin
      r_pair_valid <= r_b_valid;
      if (r_b_valid) begin
        r_home_pos <= bus.i_home_rdata;
        r_nb_pos   <= bus.i_nb_rdata;
        r_home_id  <= r_b_home_id;
        r_nb_id    <= r_b_nb_id;
      end
    end
  end

  assign bus.o_home_addr  = r_home_addr;
  assign bus.o_nb_addr    = r_nb_addr;
  assign bus.o_home_pos   = r_home_pos;
  assign bus.o_nb_pos     = r_nb_pos;
  assign bus.o_home_id    = r_home_id;
  assign bus.o_nb_id      = r_nb_id;
  assign bus.o_pair_valid = r_pair_valid;
  assign bus.o_busy       = w_busy;
  assign bus.o_done       = w_done;

endmodule
